// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch, data and memory-port signals of the shared memory arbiter.
// slave is the arbiter's view; master is the pipeline/memory side.
interface mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_rdata, if_ready, d_rdata, d_ready,
        output mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_rdata, if_ready, d_rdata, d_ready,
        input  mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: one fixed-latency memory port shared by fetch and data.
// Data wins ties unless fetch has been passed over STREAK times in a row.
module mem_arbiter #(
    parameter int MEM_LATENCY = 2,
    parameter int STREAK      = 4
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [3:0] LAT = 4'(MEM_LATENCY);
    localparam logic [3:0] LIM = 4'(STREAK);

    logic [1:0] state;
    logic [3:0] streak_cnt;
    logic [3:0] wait_cnt;
    logic       owner_d;
    logic       lat_we;
    logic       pick_d;

    assign pick_d = bus.d_req &&
                    !(bus.if_req && streak_cnt == LIM);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            streak_cnt    <= 4'd0;
            wait_cnt      <= 4'd0;
            owner_d       <= 1'b0;
            lat_we        <= 1'b0;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= 32'd0;
            bus.mem_wdata <= 32'd0;
            bus.if_ready  <= 1'b0;
            bus.d_ready   <= 1'b0;
            bus.if_rdata  <= 32'd0;
            bus.d_rdata   <= 32'd0;
            bus.busy      <= 1'b0;
        end else begin
            bus.mem_en   <= 1'b0;
            bus.mem_we   <= 1'b0;
            bus.if_ready <= 1'b0;
            bus.d_ready  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.if_req || bus.d_req) begin
                        state      <= ISSUE;
                        bus.busy   <= 1'b1;
                        bus.mem_en <= 1'b1;
                        owner_d    <= pick_d;
                        if (pick_d) begin
                            bus.mem_addr  <= bus.d_addr;
                            bus.mem_wdata <= bus.d_wdata;
                            bus.mem_we    <= bus.d_we;
                            lat_we        <= bus.d_we;
                            // streak only counts grants that bypassed a waiting fetch
                            if (!bus.if_req)
                                streak_cnt <= 4'd0;
                            else if (streak_cnt < LIM)
                                streak_cnt <= streak_cnt + 4'd1;
                        end else begin
                            bus.mem_addr <= bus.if_addr;
                            lat_we       <= 1'b0;
                            streak_cnt   <= 4'd0;
                        end
                    end
                end
                ISSUE: begin
                    state    <= WAIT;
                    wait_cnt <= LAT;
                end
                WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt == 4'd1) begin
                        state <= DONE;
                        if (owner_d) begin
                            bus.d_ready <= 1'b1;
                            if (!lat_we)
                                bus.d_rdata <= bus.mem_rdata;
                        end else begin
                            bus.if_ready <= 1'b1;
                            bus.if_rdata <= bus.mem_rdata;
                        end
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
